// File: rtl/gpio_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bus_bridge
// Description : CPU-side register front end for the GPIO port array. Holds
//               per-port DIR/OUT registers, synchronises received pin data,
//               latches rising-edge events into write-1-to-clear flags and
//               raises a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bus_bridge #(
    parameter int N           = 15,
    parameter int NUM_PORTS   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_PORTS:0]                   i_port_select,
    input  logic [1:0]                           i_reg,
    input  logic                                 i_wr_en,
    input  logic                                 i_rd_en,
    input  logic [N:0]                           i_wdata,
    output logic [N:0]                           o_rdata,
    output logic                                 o_ready,
    output logic                                 o_err,
    output logic [(NUM_PORTS+1)*(N+1)-1:0]       o_data_dir,
    output logic [(NUM_PORTS+1)*(N+1)-1:0]       o_data_transmit,
    input  logic [(NUM_PORTS+1)*(N+1)-1:0]       i_data_received,
    output logic                                 o_irq
);

    localparam int c_w     = N + 1;
    localparam int c_p     = NUM_PORTS + 1;
    localparam int c_pw    = c_p * c_w;
    localparam int c_idx_w = (c_p > 1) ? $clog2(c_p) : 1;

    localparam logic [c_p-1:0] c_one = c_p'(1);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_ack  = 1'b1;

    localparam logic [1:0] c_reg_dir  = 2'd0;
    localparam logic [1:0] c_reg_out  = 2'd1;
    localparam logic [1:0] c_reg_in   = 2'd2;
    localparam logic [1:0] c_reg_flag = 2'd3;

    logic [0:0]          r_state;
    logic [c_pw-1:0]     r_dir;
    logic [c_pw-1:0]     r_out;
    logic [c_pw-1:0]     r_flag;
    logic [c_pw-1:0]     r_prev;
    logic [c_pw-1:0]     r_sync [SYNC_STAGES];
    logic [c_w-1:0]      r_rdata;
    logic                r_err;

    logic                w_req;
    logic                w_onehot;
    logic                w_err;
    logic                w_decode;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_w-1:0]      w_sel_data;
    logic [c_pw-1:0]     w_sync_out;
    logic [c_pw-1:0]     w_rise;
    logic [c_pw-1:0]     w_clr_mask;

    assign w_req      = i_wr_en | i_rd_en;
    assign w_onehot   = (i_port_select != '0) &&
                        ((i_port_select & (i_port_select - c_one)) == '0);
    assign w_err      = !w_onehot || (i_wr_en && i_rd_en) ||
                        (i_wr_en && (i_reg == c_reg_in));
    // A request is decoded only on the IDLE->ACK edge
    assign w_decode   = (r_state == c_idle) && w_req;
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    // Only input-configured bits may raise a flag
    assign w_rise     = w_sync_out & ~r_prev & ~r_dir;

    // Convert the one-hot select into a port index
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < c_p; k++) begin
            if (i_port_select[k]) begin
                w_idx = c_idx_w'(k);
            end
        end
    end

    // Read-data mux for the selected port and register
    always_comb begin
        w_sel_data = '0;
        case (i_reg)
            c_reg_dir:  w_sel_data = r_dir[w_idx*c_w +: c_w];
            c_reg_out:  w_sel_data = r_out[w_idx*c_w +: c_w];
            c_reg_in:   w_sel_data = w_sync_out[w_idx*c_w +: c_w];
            default:    w_sel_data = r_flag[w_idx*c_w +: c_w];
        endcase
    end

    // W1C clear mask for a valid FLAG write to the selected port
    always_comb begin
        w_clr_mask = '0;
        if (w_decode && !w_err && i_wr_en && (i_reg == c_reg_flag)) begin
            w_clr_mask[w_idx*c_w +: c_w] = i_wdata;
        end
    end

    // Synchroniser chain on asynchronous pin data plus previous-value register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_data_received;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_out;
        end
    end

    // Edge flags: a set on the same bit and cycle as a W1C clear wins
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag <= '0;
        end else begin
            r_flag <= (r_flag & ~w_clr_mask) | w_rise;
        end
    end

    // Bus handshake FSM with register writes and read-data capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_idle;
            r_dir   <= '0;
            r_out   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_req) begin
                        r_state <= c_ack;
                        r_err   <= w_err;
                        if (w_err || !i_rd_en) begin
                            r_rdata <= '0;
                        end else begin
                            r_rdata <= w_sel_data;
                        end
                        if (!w_err && i_wr_en && (i_reg == c_reg_dir)) begin
                            r_dir[w_idx*c_w +: c_w] <= i_wdata;
                        end
                        if (!w_err && i_wr_en && (i_reg == c_reg_out)) begin
                            r_out[w_idx*c_w +: c_w] <= i_wdata;
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign o_ready         = (r_state == c_ack);
    assign o_rdata         = r_rdata;
    assign o_err           = r_err;
    assign o_data_dir      = r_dir;
    assign o_data_transmit = r_out;
    assign o_irq           = |r_flag;

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_bus_bridge
// Description : Directed self-checking bench for gpio_bus_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gpio_bus_bridge;

    localparam int N           = 15;
    localparam int NUM_PORTS   = 3;
    localparam int SYNC_STAGES = 2;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [3:0]  r_sel;
    logic [1:0]  r_reg;
    logic        r_wr;
    logic        r_rd;
    logic [15:0] r_wdata;
    logic [63:0] r_pins;

    logic [15:0] w_rdata;
    logic        w_ready;
    logic        w_err;
    logic [63:0] w_dir;
    logic [63:0] w_tx;
    logic        w_irq;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    logic [15:0] rd;
    logic        er;
    logic [5:0]  pat;
    int          cnt;

    gpio_bus_bridge #(
        .N           (N),
        .NUM_PORTS   (NUM_PORTS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .i_clk           (r_clk),
        .i_rst           (r_rst),
        .i_port_select   (r_sel),
        .i_reg           (r_reg),
        .i_wr_en         (r_wr),
        .i_rd_en         (r_rd),
        .i_wdata         (r_wdata),
        .o_rdata         (w_rdata),
        .o_ready         (w_ready),
        .o_err           (w_err),
        .o_data_dir      (w_dir),
        .o_data_transmit (w_tx),
        .i_data_received (r_pins),
        .o_irq           (w_irq)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // One request, held until o_ready, then dropped; returns rdata/err seen in ACK
    task automatic xact(input logic [3:0] sel, input logic [1:0] rg, input logic wr,
                        input logic rdq, input logic [15:0] wd,
                        output logic [15:0] rdat, output logic erq);
        int n;
        r_sel = sel; r_reg = rg; r_wr = wr; r_rd = rdq; r_wdata = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!w_ready && n < 4);
        check("ready_latency", {62'b0, (n == 1), w_ready}, 64'd3);
        rdat = w_rdata;
        erq  = w_err;
        r_wr = 1'b0; r_rd = 1'b0; r_sel = 4'b0000;
        tick();
        check("ready_one_cycle", {63'b0, w_ready}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with requests active
        r_rst = 1'b1; r_sel = 4'b0001; r_reg = 2'd0; r_wr = 1'b1; r_rd = 1'b1;
        r_wdata = 16'hFFFF; r_pins = '0;
        tick(); tick();
        check("reset_ready", {63'b0, w_ready}, 64'd0);
        check("reset_irq",   {63'b0, w_irq},   64'd0);
        check("reset_dir",   w_dir, 64'd0);
        check("reset_tx",    w_tx,  64'd0);
        r_rst = 1'b0; r_wr = 1'b0; r_rd = 1'b0; r_sel = 4'b0000;
        tick();
        xact(4'b0001, 2'd0, 1'b0, 1'b1, 16'h0000, rd, er);
        check("reset_dir_read", {48'b0, rd}, 64'd0);
        check("reset_dir_err",  {63'b0, er}, 64'd0);

        // Write / read port 2
        xact(4'b0100, 2'd0, 1'b1, 1'b0, 16'h00FF, rd, er);
        check("wr_dir_err", {63'b0, er}, 64'd0);
        check("wr_dir", w_dir, 64'h0000_00FF_0000_0000);
        xact(4'b0100, 2'd1, 1'b1, 1'b0, 16'hA5A5, rd, er);
        check("wr_out", w_tx, 64'h0000_A5A5_0000_0000);
        xact(4'b0100, 2'd0, 1'b0, 1'b1, 16'h0000, rd, er);
        check("rd_dir", {48'b0, rd}, 64'h00FF);
        xact(4'b0100, 2'd1, 1'b0, 1'b1, 16'h0000, rd, er);
        check("rd_out", {48'b0, rd}, 64'hA5A5);
        check("rd_out_err", {63'b0, er}, 64'd0);

        // Error cases
        xact(4'b0110, 2'd1, 1'b1, 1'b0, 16'h1234, rd, er);
        check("err_multihot", {63'b0, er}, 64'd1);
        check("err_multihot_rdata", {48'b0, rd}, 64'd0);
        check("err_multihot_tx", w_tx, 64'h0000_A5A5_0000_0000);
        xact(4'b0100, 2'd1, 1'b0, 1'b1, 16'h0000, rd, er);
        xact(4'b0000, 2'd0, 1'b0, 1'b1, 16'h0000, rd, er);
        check("err_zero_sel", {63'b0, er}, 64'd1);
        check("err_zero_sel_rdata", {48'b0, rd}, 64'd0);
        xact(4'b0100, 2'd1, 1'b1, 1'b1, 16'hFFFF, rd, er);
        check("err_wr_rd", {63'b0, er}, 64'd1);
        check("err_wr_rd_rdata", {48'b0, rd}, 64'd0);
        check("err_wr_rd_tx", w_tx, 64'h0000_A5A5_0000_0000);
        xact(4'b0100, 2'd2, 1'b1, 1'b0, 16'hFFFF, rd, er);
        check("err_in_write", {63'b0, er}, 64'd1);
        check("err_in_write_rdata", {48'b0, rd}, 64'd0);
        check("err_in_write_dir", w_dir, 64'h0000_00FF_0000_0000);
        check("err_in_write_tx", w_tx, 64'h0000_A5A5_0000_0000);
        check("err_irq", {63'b0, w_irq}, 64'd0);

        // Rising edge on port-1 bit 3 (input)
        r_pins[19] = 1'b1;
        tick(); tick();
        check("edge_irq_early", {63'b0, w_irq}, 64'd0);
        tick();
        check("edge_irq", {63'b0, w_irq}, 64'd1);
        xact(4'b0010, 2'd3, 1'b0, 1'b1, 16'h0000, rd, er);
        check("edge_flag_read", {48'b0, rd}, 64'h0008);
        xact(4'b0010, 2'd2, 1'b0, 1'b1, 16'h0000, rd, er);
        check("edge_in_read", {48'b0, rd}, 64'h0008);
        xact(4'b0010, 2'd3, 1'b1, 1'b0, 16'h0008, rd, er);
        check("w1c_irq", {63'b0, w_irq}, 64'd0);

        // Falling edge sets nothing
        r_pins[19] = 1'b0;
        repeat (5) tick();
        check("fall_irq", {63'b0, w_irq}, 64'd0);
        xact(4'b0010, 2'd3, 1'b0, 1'b1, 16'h0000, rd, er);
        check("fall_flag", {48'b0, rd}, 64'd0);

        // Output-configured bit toggling sets nothing
        xact(4'b0010, 2'd0, 1'b1, 1'b0, 16'h0010, rd, er);
        r_pins[20] = 1'b1;
        repeat (5) tick();
        check("outbit_irq", {63'b0, w_irq}, 64'd0);
        xact(4'b0010, 2'd3, 1'b0, 1'b1, 16'h0000, rd, er);
        check("outbit_flag", {48'b0, rd}, 64'd0);
        xact(4'b0010, 2'd2, 1'b0, 1'b1, 16'h0000, rd, er);
        check("outbit_in", {48'b0, rd}, 64'h0010);
        r_pins[20] = 1'b0;
        repeat (5) tick();

        // W1C race: clear and new set of bit 3 on the same edge
        r_pins[19] = 1'b1;
        repeat (5) tick();
        check("race_pre_irq", {63'b0, w_irq}, 64'd1);
        r_pins[19] = 1'b0;
        repeat (5) tick();
        r_pins[19] = 1'b1;
        tick(); tick();
        xact(4'b0010, 2'd3, 1'b1, 1'b0, 16'h0008, rd, er);
        check("race_irq", {63'b0, w_irq}, 64'd1);
        xact(4'b0010, 2'd3, 1'b0, 1'b1, 16'h0000, rd, er);
        check("race_flag", {48'b0, rd}, 64'h0008);
        xact(4'b0010, 2'd3, 1'b1, 1'b0, 16'h0008, rd, er);
        check("race_clear_irq", {63'b0, w_irq}, 64'd0);

        // Back-to-back reads held for 6 cycles
        r_sel = 4'b0100; r_reg = 2'd0; r_rd = 1'b1;
        pat = '0; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat = {pat[4:0], w_ready};
            if (w_ready) cnt++;
        end
        r_rd = 1'b0; r_sel = 4'b0000;
        check("b2b_pattern", {58'b0, pat}, 64'b101010);
        check("b2b_count", 64'(cnt), 64'd3);
        check("b2b_rdata", {48'b0, w_rdata}, 64'h00FF);
        tick();
        check("b2b_idle", {63'b0, w_ready}, 64'd0);

        // Reset in the middle of a transaction
        r_sel = 4'b0100; r_reg = 2'd1; r_wr = 1'b1; r_wdata = 16'h1111;
        tick();
        check("mid_ack", {63'b0, w_ready}, 64'd1);
        check("mid_tx", w_tx, 64'h0000_1111_0000_0000);
        r_rst = 1'b1; r_wr = 1'b0; r_sel = 4'b0000;
        tick();
        check("mid_rst_ready", {63'b0, w_ready}, 64'd0);
        check("mid_rst_dir", w_dir, 64'd0);
        check("mid_rst_tx", w_tx, 64'd0);
        r_rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
